// File: rtl/sequence_checker_16x4.sv
// sequence_checker_16x4: replays the stored move sequence from RAM against player moves
module sequence_checker_16x4 #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] last_idx,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   input  logic              play_valid,
   input  logic [DATA_W-1:0] play_data,
   output logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] cur_idx,
   output logic              hit,
   output logic              miss,
   output logic              timed_out
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, COMPARE} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] last, last_n, addr_n, idx_n;
   logic [DATA_W-1:0] expected, expected_n, move, move_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic hit_n, miss_n, to_n;
   assign ready = state == WAIT;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         last <= '0;
         mem_addr <= '0;
         cur_idx <= '0;
         expected <= '0;
         move <= '0;
         cnt <= '0;
         hit <= 1'b0;
         miss <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         state <= state_n;
         last <= last_n;
         mem_addr <= addr_n;
         cur_idx <= idx_n;
         expected <= expected_n;
         move <= move_n;
         cnt <= cnt_n;
         hit <= hit_n;
         miss <= miss_n;
         timed_out <= to_n;
      end
   end
   always_comb begin
      state_n = state;
      last_n = last;
      addr_n = mem_addr;
      idx_n = cur_idx;
      expected_n = expected;
      move_n = move;
      cnt_n = cnt;
      hit_n = hit;
      miss_n = miss;
      to_n = timed_out;
      unique case (state)
         IDLE: if (start) begin
            state_n = FETCH;
            last_n = last_idx;
            addr_n = '0;
            idx_n = '0;
            hit_n = 1'b0;
            miss_n = 1'b0;
            to_n = 1'b0;
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            expected_n = mem_q;
            cnt_n = '0;
            state_n = WAIT;
         end
         // a move arriving on the final timeout cycle takes priority
         WAIT: if (play_valid) begin
            move_n = play_data;
            state_n = COMPARE;
         end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_n = 1'b1;
            state_n = IDLE;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
         COMPARE: if (move != expected) begin
            miss_n = 1'b1;
            state_n = IDLE;
         end else if (cur_idx == last) begin
            hit_n = 1'b1;
            state_n = IDLE;
         end else begin
            idx_n = cur_idx + ADDR_W'(1);
            addr_n = mem_addr + ADDR_W'(1);
            state_n = FETCH;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sequence_checker_16x4.sv
// tb_sequence_checker_16x4: directed rounds checked against a latency-level model every cycle
module tb_sequence_checker_16x4;
   localparam int T = 8;
   logic clk = 1'b0;
   logic reset_n, start, play_valid;
   logic [3:0] last_idx, mem_addr, mem_q, play_data, cur_idx;
   logic ready, busy, hit, miss, timed_out;
   logic [3:0] ram [16];
   int checks = 0;
   int errors = 0;
   sequence_checker_16x4 #(.TIMEOUT_CYCLES(T), .ADDR_W(4), .DATA_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .last_idx(last_idx),
      .mem_addr(mem_addr), .mem_q(mem_q), .play_valid(play_valid), .play_data(play_data),
      .ready(ready), .busy(busy), .cur_idx(cur_idx), .hit(hit), .miss(miss), .timed_out(timed_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) mem_q <= ram[mem_addr];
   // model: a round is a walk over indices with fixed fetch delay, a move wait and a judge cycle
   logic m_act, m_cmp, m_hit, m_miss, m_to;
   int m_delay, m_tcnt;
   logic [3:0] m_idx, m_last, m_move;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_act <= 0; m_cmp <= 0; m_hit <= 0; m_miss <= 0; m_to <= 0;
         m_delay <= 0; m_tcnt <= 0; m_idx <= 0; m_last <= 0; m_move <= 0;
      end else if (!m_act) begin
         if (start) begin
            m_act <= 1; m_idx <= 0; m_last <= last_idx; m_delay <= 2; m_tcnt <= 0;
            m_hit <= 0; m_miss <= 0; m_to <= 0;
         end
      end else if (m_delay > 0) begin
         m_delay <= m_delay - 1;
      end else if (m_cmp) begin
         m_cmp <= 0;
         if (m_move != ram[m_idx]) begin m_miss <= 1; m_act <= 0; end
         else if (m_idx == m_last) begin m_hit <= 1; m_act <= 0; end
         else begin m_idx <= m_idx + 1; m_delay <= 2; m_tcnt <= 0; end
      end else if (play_valid) begin
         m_cmp <= 1; m_move <= play_data;
      end else if (m_tcnt == T - 1) begin
         m_to <= 1; m_act <= 0;
      end else begin
         m_tcnt <= m_tcnt + 1;
      end
   end
   wire m_ready = m_act && m_delay == 0 && !m_cmp;
   wire [12:0] exp_vec = {m_ready, m_act, m_idx, m_idx, m_hit, m_miss, m_to};
   wire [12:0] act_vec = {ready, busy, cur_idx, mem_addr, hit, miss, timed_out};
   always @(negedge clk) begin
      checks++;
      if (act_vec !== exp_vec) begin
         errors++;
         $display("FAIL model t=%0t rdy,busy,idx,addr,hit,miss,to got %b expected %b", $time, act_vec, exp_vec);
      end
   end
   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic go(input logic [3:0] l);
      start = 1; last_idx = l;
      step();
      start = 0; last_idx = ~l;
   endtask
   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 40) begin step(); n++; end
      if (!ready) begin
         checks++; errors++;
         $display("FAIL wait_ready got ready=%b expected 1", ready);
      end
   endtask
   task automatic play(input logic [3:0] d);
      wait_ready();
      play_valid = 1; play_data = d;
      step();
      play_valid = 0; play_data = 0;
   endtask
   task automatic load4();
      ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4; ram[3] = 4'd8;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end
   initial begin
      logic [3:0] seq [4];
      seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd8;
      for (int i = 0; i < 16; i++) ram[i] = 4'd0;
      reset_n = 0; start = 0; play_valid = 0; play_data = 0; last_idx = 0;
      repeat (3) step();
      chk("reset_state", act_vec, 13'd0);
      reset_n = 1;
      step();
      // 1: full correct round
      load4();
      go(3);
      step();
      chk("pre_ready", {12'd0, ready}, 13'd0);
      step();
      chk("start_to_ready", {12'd0, ready}, 13'd1);
      for (int i = 0; i < 4; i++) begin
         wait_ready();
         chk("addr_visit", {9'd0, mem_addr}, 13'(i));
         play(seq[i]);
      end
      step();
      chk("t1_result", {10'd0, hit, miss, timed_out}, 13'b100);
      chk("t1_busy", {12'd0, busy}, 13'd0);
      // 2: wrong third move
      go(3);
      play(1); play(2); play(8);
      step();
      chk("t2_result", {10'd0, hit, miss, timed_out}, 13'b010);
      chk("t2_idx_busy", {8'd0, cur_idx, busy}, 13'b00100);
      // 3: timeout, then a move on the last allowed cycle
      go(0);
      wait_ready();
      repeat (T - 1) step();
      chk("t3_no_to_yet", {11'd0, ready, timed_out}, 13'b10);
      step();
      chk("t3_timeout", {10'd0, timed_out, busy, hit}, 13'b100);
      go(0);
      wait_ready();
      repeat (T - 1) step();
      play_valid = 1; play_data = 4'd1;
      step();
      play_valid = 0; play_data = 0;
      step();
      chk("t3_late_move", {10'd0, hit, miss, timed_out}, 13'b100);
      // 4: sixteen-move round with stray pulses while not ready
      for (int i = 0; i < 16; i++) ram[i] = 4'd1;
      go(15);
      for (int i = 0; i < 16; i++) begin
         play(1);
         if (i < 15) begin
            play_valid = 1; play_data = 4'd2;
            step();
            play_valid = 0; play_data = 0;
         end
      end
      step();
      chk("t4_result", {10'd0, hit, miss, timed_out}, 13'b100);
      chk("t4_idx_addr", {5'd0, cur_idx, mem_addr}, 13'hff);
      // 5: ignored restart, then reset mid-check
      load4();
      go(3);
      play(1);
      start = 1;
      step();
      start = 0;
      wait_ready();
      chk("t5_no_restart", {9'd0, cur_idx}, 13'd1);
      play(2);
      wait_ready();
      chk("t5_at_idx2", {9'd0, cur_idx}, 13'd2);
      reset_n = 0;
      #1;
      chk("t5_async_reset", act_vec, 13'd0);
      step();
      reset_n = 1;
      step();
      go(3);
      wait_ready();
      chk("t5_from_zero", {9'd0, cur_idx}, 13'd0);
      for (int i = 0; i < 4; i++) play(seq[i]);
      step();
      chk("t5_result", {10'd0, hit, miss, timed_out}, 13'b100);
      // 6: single-move round, hit then multi-hot miss
      ram[0] = 4'b0100;
      go(0);
      play(4'b0100);
      step();
      chk("t6_hit", {10'd0, hit, miss, timed_out}, 13'b100);
      go(0);
      chk("t6_hit_cleared", {12'd0, hit}, 13'd0);
      play(4'b0110);
      step();
      chk("t6_miss", {10'd0, hit, miss, timed_out}, 13'b010);
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
